// File: rtl/bitmask_assembler.sv
`default_nettype none
// bitmask_assembler: rebuilds 7-bit masks from a 3-bit index stream, rev 1.0.
// Define BITMASK_ASM_ERR_EN to flag duplicate or idx=7 beats on out_err.
module bitmask_assembler (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] in_idx,
  input  logic       in_nz,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [6:0] out_mask,
  output logic [2:0] out_cnt,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready
);

  logic [6:0] acc;
  logic [6:0] beat_bit;
  logic [6:0] mask_next;
  logic [2:0] cnt_next;
  logic       fire;

  assign in_ready = !out_valid || out_ready;
  assign fire     = in_valid && in_ready;

  // idx 7 is out of range for a 7-bit mask and contributes nothing
  assign beat_bit  = (in_nz && (in_idx != 3'd7)) ? (7'd1 << in_idx) : 7'd0;
  assign mask_next = acc | beat_bit;

  always_comb begin
    cnt_next = 3'd0;
    for (int i = 0; i < 7; i++) begin
      cnt_next = cnt_next + {2'b00, mask_next[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= 7'd0;
      out_mask  <= 7'd0;
      out_cnt   <= 3'd0;
      out_valid <= 1'b0;
    end else begin
      if (fire) begin
        acc <= in_last ? 7'd0 : mask_next;
      end
      if (fire && in_last) begin
        out_mask  <= mask_next;
        out_cnt   <= cnt_next;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef BITMASK_ASM_ERR_EN
  logic err_acc;
  logic beat_err;
  logic out_err_r;

  assign beat_err = in_nz && ((in_idx == 3'd7) || ((acc & beat_bit) != 7'd0));
  assign out_err  = out_err_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_acc   <= 1'b0;
      out_err_r <= 1'b0;
    end else if (fire) begin
      err_acc <= in_last ? 1'b0 : (err_acc | beat_err);
      if (in_last) begin
        out_err_r <= err_acc | beat_err;
      end
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitmask_assembler.sv
`default_nettype none
// Scoreboard bench for bitmask_assembler with a set-based reference model.
module tb_bitmask_assembler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] in_idx = 3'd0;
  logic       in_nz = 1'b0;
  logic       in_last = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] out_mask;
  logic [2:0] out_cnt;
  logic       out_err;
  logic       out_valid;
  logic       out_ready = 1'b1;

  bitmask_assembler dut (
    .clk(clk), .reset(reset), .in_idx(in_idx), .in_nz(in_nz),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_mask(out_mask), .out_cnt(out_cnt), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] m;
    logic [2:0] c;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: the set of positions seen in the open group.
  bit   seen[7];
  bit   grp_err;
  bit   pend;
  exp_t pend_e;
  bit   rnd_ready = 1'b0;
  bit   forced_ready = 1'b1;

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 7; i++) seen[i] = 1'b0;
    grp_err = 1'b0;
  endfunction

  function automatic exp_t model_result();
    exp_t r;
    int   m = 0;
    int   c = 0;
    for (int i = 0; i < 7; i++) begin
      if (seen[i]) begin
        m = m + (2 ** i);
        c = c + 1;
      end
    end
    r.m = 7'(m);
    r.c = 3'(c);
`ifdef BITMASK_ASM_ERR_EN
    r.e = grp_err;
`else
    r.e = 1'b0;
`endif
    return r;
  endfunction

  // Monitor: handshake visibility and output contents against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      chk("out_valid", int'(out_valid), int'(q.size() != 0));
      chk("in_ready", int'(in_ready), int'((q.size() == 0) || out_ready));
      if (out_valid && q.size() != 0) begin
        chk("out_mask", int'(out_mask), int'(q[0].m));
        chk("out_cnt", int'(out_cnt), int'(q[0].c));
        chk("out_err", int'(out_err), int'(q[0].e));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic drive(input bit v, input bit nz, input logic [2:0] idx,
                       input bit last, output bit fired);
    @(posedge clk);
    if (pend) begin
      q.push_back(pend_e);
      pend = 1'b0;
    end
    #1;
    in_valid  = v;
    in_nz     = nz;
    in_idx    = idx;
    in_last   = last;
    out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
    @(negedge clk);
    fired = in_valid && in_ready;
    if (fired) begin
      if (nz) begin
        if (idx == 3'd7) grp_err = 1'b1;
        else begin
          if (seen[idx]) grp_err = 1'b1;
          seen[idx] = 1'b1;
        end
      end
      if (last) begin
        pend_e = model_result();
        pend   = 1'b1;
        model_clear();
      end
    end
  endtask

  task automatic send(input bit nz, input logic [2:0] idx, input bit last);
    bit f;
    int n = 0;
    do begin
      drive(1'b1, nz, idx, last, f);
      n++;
    end while (!f && n < 50);
    if (!f) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  task automatic idle(input int n);
    bit f;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, 1'b0, f);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    q.delete();
    pend = 1'b0;
    model_clear();
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_mask", int'(out_mask), 0);
    chk("rst_out_cnt", int'(out_cnt), 0);
    chk("rst_out_err", int'(out_err), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bit f;
    exp_t e;
    model_clear();
    pend = 1'b0;
    do_reset();

    // Three-beat group and a zero-group marker
    send(1'b1, 3'd6, 1'b0);
    send(1'b1, 3'd3, 1'b0);
    send(1'b1, 3'd0, 1'b1);
    e = pend_e;
    chk("plan_mask_1001001", int'(e.m), 7'b1001001);
    send(1'b0, 3'd5, 1'b1);
    send(1'b1, 3'd2, 1'b0);
    send(1'b1, 3'd2, 1'b1);
    send(1'b1, 3'd7, 1'b0);
    send(1'b1, 3'd1, 1'b1);
    idle(3);

    // Backpressure: group A stalls, B waits, then both move on the same edge
    forced_ready = 1'b0;
    send(1'b1, 3'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 3'd4, 1'b1, f);
      chk("stalled_accept", int'(f), 0);
    end
    forced_ready = 1'b1;
    drive(1'b1, 1'b1, 3'd4, 1'b1, f);
    chk("release_accept", int'(f), 1);
    idle(2);

    // Reset mid-group discards the partial bit 6
    send(1'b1, 3'd6, 1'b0);
    do_reset();
    send(1'b1, 3'd1, 1'b1);
    idle(2);

    // Randomized groups with gaps and random downstream backpressure
    rnd_ready = 1'b1;
    for (int g = 0; g < 300; g++) begin
      int len = $urandom_range(1, 9);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
        send($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)), b == len - 1);
      end
    end
    rnd_ready = 1'b0;
    forced_ready = 1'b1;
    idle(4);
    chk("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
